// File: rtl/ram_read_arbiter.sv
// Round-robin arbiter sharing one block-RAM read port among NUM_REQ requesters, with write passthrough.
// Define RAM_ARB_FIXED_PRIORITY_EN for fixed lowest-index-wins arbitration instead of round-robin.
module ram_read_arbiter #(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 32,
    parameter int NUM_REQ      = 4,
    parameter int READ_LATENCY = 2,
    localparam int ADDR_W      = $clog2(DEPTH),
    localparam int PTR_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    output logic [NUM_REQ-1:0]         req_grant,
    output logic [NUM_REQ-1:0]         resp_valid,
    output logic [WIDTH-1:0]           resp_data,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [WIDTH-1:0]           wr_data,
    output logic                       ram_write,
    output logic [ADDR_W-1:0]          ram_addra,
    output logic [WIDTH-1:0]           ram_dina,
    output logic                       ram_read,
    output logic [ADDR_W-1:0]          ram_addrb,
    input  logic [WIDTH-1:0]           ram_doutb,
    output logic                       busy
);

    logic [ADDR_W-1:0]  addr_arr [NUM_REQ];
    logic [NUM_REQ-1:0] eligible;
    logic               grant_found;
    logic [PTR_W-1:0]   grant_idx;

    assign ram_write = wr_en & ~rst;
    assign ram_addra = wr_addr;
    assign ram_dina  = wr_data;

    // A read that hits the address being written this cycle is held off, not dropped.
    for (genvar g = 0; g < NUM_REQ; g++) begin : gen_req
        assign addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
        assign eligible[g] = req_valid[g] & ~rst & ~(wr_en && (addr_arr[g] == wr_addr));
    end

`ifdef RAM_ARB_FIXED_PRIORITY_EN

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (eligible[k]) begin
                grant_found = 1'b1;
                grant_idx   = PTR_W'(k);
            end
        end
    end

`else

    logic [PTR_W-1:0] ptr;
    logic [PTR_W:0]   scan;

    // The extra scan bit lets ptr+k be wrapped explicitly for non-power-of-two NUM_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = {1'b0, ptr} + (PTR_W+1)'(k);
            if (scan >= (PTR_W+1)'(NUM_REQ)) begin
                scan = scan - (PTR_W+1)'(NUM_REQ);
            end
            if (!grant_found && eligible[scan[PTR_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = scan[PTR_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (grant_found) begin
            if (grant_idx == PTR_W'(NUM_REQ - 1)) begin
                ptr <= '0;
            end else begin
                ptr <= grant_idx + 1'b1;
            end
        end
    end

`endif

    always_comb begin
        req_grant = '0;
        ram_addrb = '0;
        if (grant_found) begin
            req_grant[grant_idx] = 1'b1;
            ram_addrb            = addr_arr[grant_idx];
        end
    end

    assign ram_read = grant_found;

    // Tags travel alongside the RAM's read latency so data lines up with its issuer.
    logic [READ_LATENCY-1:0] tag_valid;
    logic [NUM_REQ-1:0]      tag_id [READ_LATENCY];

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_valid <= '0;
            for (int s = 0; s < READ_LATENCY; s++) begin
                tag_id[s] <= '0;
            end
        end else begin
            tag_valid[0] <= ram_read;
            tag_id[0]    <= req_grant;
            for (int s = 1; s < READ_LATENCY; s++) begin
                tag_valid[s] <= tag_valid[s-1];
                tag_id[s]    <= tag_id[s-1];
            end
        end
    end

    assign resp_valid = tag_valid[READ_LATENCY-1] ? tag_id[READ_LATENCY-1] : '0;
    assign resp_data  = ram_doutb;
    assign busy       = |tag_valid;

endmodule
